// File: rtl/piso_pkg.sv
// Shared definitions for the serial link: shifter state encoding and default word width.
package piso_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic {IDLE, SHIFT} state_t;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: one-word holding register feeding an MSB-first
// shifter, with back-to-back words streamed without an idle bit between them.
module piso_tx
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  ONE  = CW'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_hold;
   logic             r_hold_full;
   logic [WIDTH-1:0] r_sreg;
   logic [CW-1:0]    r_cnt;
   logic             w_last;
   logic             w_load;
   logic             w_accept;

   always_comb begin
      w_last      = (r_cnt == LAST);
      w_accept    = din_valid && !r_hold_full;
      // A held word is loaded on the same edge the previous word's last bit retires,
      // so streaming words are gapless.
      w_load      = r_hold_full && ((r_state == IDLE) || w_last);
      w_state_nxt = r_state;
      if (w_load) begin
         w_state_nxt = SHIFT;
      end else if ((r_state == SHIFT) && w_last) begin
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_state     <= IDLE;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_sreg      <= '0;
         r_cnt       <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_hold      <= din;
            r_hold_full <= 1'b1;
         end
         if (w_load) begin
            r_sreg      <= r_hold;
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
         end else if (r_state == SHIFT) begin
            if (!w_last) begin
               r_sreg <= r_sreg << 1;
               r_cnt  <= r_cnt + ONE;
            end else begin
               r_cnt  <= '0;
            end
         end
      end
   end

   always_comb begin
      din_ready  = !r_hold_full;
      dout_valid = (r_state == SHIFT);
      dout       = (r_state == SHIFT) && r_sreg[WIDTH-1];
      word_done  = (r_state == SHIFT) && w_last;
      busy       = (r_state == SHIFT) || r_hold_full;
   end

endmodule
